// File: rtl/lander_telemetry_tx.sv
// Telemetry framer: snapshots the lander's BCD readouts on each update pulse and
// streams them as a 31-byte ASCII line through the byte-wide UART transmit port.
module lander_telemetry_tx #(
    parameter int HOLDOFF       = 1,
    parameter bit SUPPRESS_HALT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        update,
    input  logic [15:0] alt,
    input  logic [15:0] vel,
    input  logic [15:0] fuel,
    input  logic [15:0] thrust,
    input  logic        land,
    input  logic        fail,
    input  logic        txready,
    output logic [7:0]  txdata,
    output logic        txclk,
    output logic        busy,
    output logic [7:0]  dropped
);

    localparam logic [4:0] LAST_IDX  = 5'd30;
    localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_HOLD,
        S_DONE,
        S_HALT
    } state_t;

    state_t      state, state_d;
    logic [4:0]  byte_idx, byte_idx_d;
    logic [3:0]  hold_cnt, hold_cnt_d;
    logic [7:0]  txdata_d, dropped_d;
    logic        txclk_d, busy_d;
    logic        capture;
    logic        halt_cond;

    logic [15:0] snap_val [4];
    logic [3:0]  snap_neg;
    logic [7:0]  snap_status;

    logic [1:0]  field;
    logic [2:0]  pos;
    logic [15:0] cur_val;
    logic [7:0]  cur_byte;

    // Ten's complement as a nibble-wise nines complement followed by a BCD increment;
    // illegal nibbles pass through the 4-bit arithmetic and surface later as '?'.
    function automatic logic [15:0] bcd_negate(input logic [15:0] v);
        logic [15:0] r;
        logic [3:0]  d;
        logic        carry;
        r     = '0;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 4'd9 - v[4*i +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    d = 4'd0;
                end else begin
                    d     = d + 4'd1;
                    carry = 1'b0;
                end
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    function automatic logic [7:0] digit_char(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
    endfunction

    function automatic logic [7:0] field_tag(input logic [1:0] f);
        case (f)
            2'd0:    return 8'h41;
            2'd1:    return 8'h56;
            2'd2:    return 8'h46;
            default: return 8'h54;
        endcase
    endfunction

    // NOTE: snapshot registers are always loaded before they are read, so they carry no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            snap_val[0] <= alt[15]    ? bcd_negate(alt)    : alt;
            snap_val[1] <= vel[15]    ? bcd_negate(vel)    : vel;
            snap_val[2] <= fuel[15]   ? bcd_negate(fuel)   : fuel;
            snap_val[3] <= thrust[15] ? bcd_negate(thrust) : thrust;
            snap_neg    <= {thrust[15], fuel[15], vel[15], alt[15]};
            snap_status <= land ? 8'h4C : (fail ? 8'h58 : 8'h2D);
        end
    end

    // Each of the four fields occupies 7 bytes: tag, sign, four digits, space.
    always_comb begin
        field    = 2'd0;
        pos      = 3'd0;
        if (byte_idx < 5'd7) begin
            pos = byte_idx[2:0];
        end else if (byte_idx < 5'd14) begin
            field = 2'd1;
            pos   = 3'(byte_idx - 5'd7);
        end else if (byte_idx < 5'd21) begin
            field = 2'd2;
            pos   = 3'(byte_idx - 5'd14);
        end else if (byte_idx < 5'd28) begin
            field = 2'd3;
            pos   = 3'(byte_idx - 5'd21);
        end
        cur_val = snap_val[field];
        case (pos)
            3'd0:    cur_byte = field_tag(field);
            3'd1:    cur_byte = snap_neg[field] ? 8'h2D : 8'h2B;
            3'd2:    cur_byte = digit_char(cur_val[15:12]);
            3'd3:    cur_byte = digit_char(cur_val[11:8]);
            3'd4:    cur_byte = digit_char(cur_val[7:4]);
            3'd5:    cur_byte = digit_char(cur_val[3:0]);
            default: cur_byte = 8'h20;
        endcase
        if (byte_idx == 5'd28) cur_byte = snap_status;
        if (byte_idx == 5'd29) cur_byte = 8'h0D;
        if (byte_idx == 5'd30) cur_byte = 8'h0A;
    end

    assign halt_cond = SUPPRESS_HALT && (snap_status != 8'h2D);

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d    = state;
        byte_idx_d = byte_idx;
        hold_cnt_d = hold_cnt;
        txdata_d   = txdata;
        txclk_d    = 1'b0;
        capture    = 1'b0;
        dropped_d  = dropped;
        if (update && state != S_IDLE && dropped != 8'hFF) begin
            dropped_d = dropped + 8'd1;
        end
        case (state)
            S_IDLE: begin
                if (update) begin
                    capture = 1'b1;
                    state_d = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (txready) begin
                    txdata_d   = cur_byte;
                    txclk_d    = 1'b1;
                    hold_cnt_d = HOLD_INIT;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_cnt != 4'd0) begin
                    hold_cnt_d = hold_cnt - 4'd1;
                end else if (byte_idx == LAST_IDX) begin
                    byte_idx_d = 5'd0;
                    state_d    = S_DONE;
                end else begin
                    byte_idx_d = byte_idx + 5'd1;
                    state_d    = S_WAIT_RDY;
                end
            end
            // One closing cycle keeps the frame period uniform before busy drops.
            S_DONE:  state_d = halt_cond ? S_HALT : S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_WAIT_RDY) || (state_d == S_HOLD) || (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            byte_idx <= 5'd0;
            hold_cnt <= 4'd0;
            txdata   <= 8'h00;
            txclk    <= 1'b0;
            busy     <= 1'b0;
            dropped  <= 8'd0;
        end else begin
            state    <= state_d;
            byte_idx <= byte_idx_d;
            hold_cnt <= hold_cnt_d;
            txdata   <= txdata_d;
            txclk    <= txclk_d;
            busy     <= busy_d;
            dropped  <= dropped_d;
        end
    end

endmodule

// File: tb/tb_lander_telemetry_tx.sv
// Self-checking bench for lander_telemetry_tx: hand-written frame table, timing
// sequences, and randomized frames checked against an arithmetic frame model.
module tb_lander_telemetry_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        update1, update2;
    logic [15:0] alt, vel, fuel, thrust;
    logic        land, fail;
    logic        txready1, txready2;
    logic [7:0]  txdata1, txdata2, dropped1, dropped2;
    logic        txclk1, txclk2, busy1, busy2;

    always #5 clk = ~clk;

    lander_telemetry_tx dut (
        .clk(clk), .reset(reset), .update(update1),
        .alt(alt), .vel(vel), .fuel(fuel), .thrust(thrust),
        .land(land), .fail(fail), .txready(txready1),
        .txdata(txdata1), .txclk(txclk1), .busy(busy1), .dropped(dropped1)
    );

    lander_telemetry_tx #(.HOLDOFF(3), .SUPPRESS_HALT(1'b0)) dut_nh (
        .clk(clk), .reset(reset), .update(update2),
        .alt(alt), .vel(vel), .fuel(fuel), .thrust(thrust),
        .land(land), .fail(fail), .txready(txready2),
        .txdata(txdata2), .txclk(txclk2), .busy(busy2), .dropped(dropped2)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  cap1[$];
    logic [7:0]  cap2[$];
    int          dbl1 = 0, dbl2 = 0;
    logic        prev1 = 1'b0, prev2 = 1'b0;
    logic [7:0]  exp_f [31];

    // Byte capture on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (txclk1) cap1.push_back(txdata1);
        if (txclk2) cap2.push_back(txdata2);
        if (txclk1 && prev1) dbl1++;
        if (txclk2 && prev2) dbl2++;
        prev1 = txclk1;
        prev2 = txclk2;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input int which);
        if (which == 1) update1 = 1'b1;
        else            update2 = 1'b1;
        step();
        update1 = 1'b0;
        update2 = 1'b0;
    endtask

    function automatic logic [7:0] dchar(input int d);
        return (d <= 9) ? 8'(48 + d) : 8'h3F;
    endfunction

    // Field model: legal negatives via decimal arithmetic, otherwise nibble by nibble.
    function automatic void put_field(input int base, input logic [7:0] tag, input logic [15:0] v);
        int n[4];
        int d[4];
        int val, m, carry;
        bit legal;
        legal = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n[i] = int'(v[4*i +: 4]);
            if (n[i] > 9) legal = 1'b0;
        end
        if (!v[15]) begin
            for (int i = 0; i < 4; i++) d[i] = n[i];
        end else if (legal) begin
            val  = n[3] * 1000 + n[2] * 100 + n[1] * 10 + n[0];
            m    = (10000 - val) % 10000;
            d[0] = m % 10;
            d[1] = (m / 10) % 10;
            d[2] = (m / 100) % 10;
            d[3] = m / 1000;
        end else begin
            carry = 1;
            for (int i = 0; i < 4; i++) begin
                d[i] = 9 - n[i];
                if (d[i] < 0) d[i] += 16;
                if (carry != 0) begin
                    if (d[i] == 9) d[i] = 0;
                    else begin
                        d[i]  = (d[i] + 1) % 16;
                        carry = 0;
                    end
                end
            end
        end
        exp_f[base]     = tag;
        exp_f[base + 1] = v[15] ? 8'h2D : 8'h2B;
        for (int k = 0; k < 4; k++) exp_f[base + 2 + k] = dchar(d[3 - k]);
        exp_f[base + 6] = 8'h20;
    endfunction

    function automatic void model_frame(input logic [15:0] a, input logic [15:0] vv,
                                        input logic [15:0] f, input logic [15:0] t,
                                        input logic ld, input logic fl);
        put_field(0,  8'h41, a);
        put_field(7,  8'h56, vv);
        put_field(14, 8'h46, f);
        put_field(21, 8'h54, t);
        exp_f[28] = ld ? 8'h4C : (fl ? 8'h58 : 8'h2D);
        exp_f[29] = 8'h0D;
        exp_f[30] = 8'h0A;
    endfunction

    function automatic void exp_from_string(input string s);
        for (int i = 0; i < 29; i++) exp_f[i] = s[i];
        exp_f[29] = 8'h0D;
        exp_f[30] = 8'h0A;
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 7) == 0) r[4*i +: 4] = 4'($urandom_range(10, 15));
            else                           r[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    task automatic check_frame(input string name, input int which);
        logic [7:0] q[$];
        int bad;
        bad = 0;
        if (which == 1) q = cap1;
        else            q = cap2;
        check({name, "_len"}, q.size(), 31);
        for (int i = 0; i < 31 && i < q.size(); i++) begin
            if (q[i] !== exp_f[i]) begin
                bad = i;
                break;
            end
        end
        if (q.size() > 0) check($sformatf("%s_byte%0d", name, bad), q[bad], exp_f[bad]);
    endtask

    // Waits for 31 captured bytes and busy low; returns the cycles spent.
    task automatic wait_frame(input int which, input int budget, output int spent);
        spent = budget;
        for (int i = 0; i < budget; i++) begin
            if (which == 1 && cap1.size() >= 31 && !busy1) begin spent = i; break; end
            if (which == 2 && cap2.size() >= 31 && !busy2) begin spent = i; break; end
            step();
        end
    endtask

    typedef struct {
        logic [15:0] a, v, f, t;
        logic        ld, fl;
        string       s;
    } vec_t;

    initial begin
        vec_t        tbl[4];
        int          errs, spent;
        logic [7:0]  held;
        logic [15:0] ra, rv, rf, rt;
        logic        rl, rx;

        tbl[0] = '{16'h4500, 16'h9995, 16'h0800, 16'h0005, 1'b0, 1'b0, "A+4500 V-0005 F+0800 T+0005 -"};
        tbl[1] = '{16'h8000, 16'h0000, 16'h9999, 16'h1234, 1'b0, 1'b1, "A-2000 V+0000 F-0001 T+1234 X"};
        tbl[2] = '{16'h0001, 16'h5000, 16'h12A4, 16'h9F01, 1'b1, 1'b1, "A+0001 V+5000 F+12?4 T-0?99 L"};
        tbl[3] = '{16'h0000, 16'h9000, 16'h0009, 16'h8765, 1'b0, 1'b0, "A+0000 V-1000 F+0009 T-1235 -"};

        reset = 1'b0; update1 = 1'b0; update2 = 1'b0;
        alt = '0; vel = '0; fuel = '0; thrust = '0; land = 1'b0; fail = 1'b0;
        txready1 = 1'b1; txready2 = 1'b1;
        steps(3);
        check("reset_txdata",  txdata1,  8'h00);
        check("reset_txclk",   txclk1,   1'b0);
        check("reset_busy",    busy1,    1'b0);
        check("reset_dropped", dropped1, 8'd0);
        reset = 1'b1;
        step();

        // Basic frame with cycle-exact strobe and busy timing; inputs change after capture.
        alt = 16'h4500; vel = 16'h9995; fuel = 16'h0800; thrust = 16'h0005;
        exp_from_string("A+4500 V-0005 F+0800 T+0005 -");
        cap1.delete();
        pulse(1);
        alt = 16'h1111; vel = 16'h2222; land = 1'b1;
        errs = 0;
        for (int rel = 1; rel <= 66; rel++) begin
            if (txclk1 !== ((rel >= 2) && (rel <= 62) && (rel % 2 == 0))) errs++;
            if (busy1 !== (rel <= 63)) errs++;
            if (rel == 2)  check("first_strobe_data", txdata1, 8'h41);
            if (rel == 63) check("busy_cycle63", busy1, 1'b1);
            if (rel == 64) check("busy_cycle64", busy1, 1'b0);
            step();
        end
        check("strobe_timing_errs", errs, 0);
        check_frame("basic", 1);

        // Backpressure after byte 5.
        alt = 16'h0123; vel = 16'h9000; fuel = 16'h0042; thrust = 16'h0007; land = 1'b0; fail = 1'b0;
        model_frame(alt, vel, fuel, thrust, land, fail);
        cap1.delete();
        pulse(1);
        for (int i = 0; i < 100 && cap1.size() < 6; i++) step();
        txready1 = 1'b0;
        held = txdata1;
        check("bp_byte5", held, exp_f[5]);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (txclk1 !== 1'b0 || txdata1 !== held) errs++;
        end
        check("bp_stall_errs", errs, 0);
        check("bp_count", cap1.size(), 6);
        txready1 = 1'b1;
        wait_frame(1, 200, spent);
        check_frame("backpressure", 1);

        // Overrun: 300 updates while the frame is stalled.
        reset = 1'b0; step(); reset = 1'b1; step();
        alt = 16'h0250; vel = 16'h0000; fuel = 16'h9999; thrust = 16'h0100;
        model_frame(alt, vel, fuel, thrust, 1'b0, 1'b0);
        cap1.delete();
        pulse(1);
        txready1 = 1'b0;
        for (int p = 1; p <= 300; p++) begin
            alt = 16'($urandom); vel = 16'($urandom); land = 1'($urandom);
            update1 = 1'b1; step(); update1 = 1'b0; step();
            if (p == 10)  check("drop_10",  dropped1, 8'd10);
            if (p == 254) check("drop_254", dropped1, 8'd254);
        end
        check("drop_sat", dropped1, 8'd255);
        land = 1'b0; fail = 1'b0;
        txready1 = 1'b1;
        wait_frame(1, 200, spent);
        check_frame("overrun", 1);

        // Reset mid-frame after byte 12.
        alt = 16'h0777; vel = 16'h0001; fuel = 16'h0300; thrust = 16'h0020;
        cap1.delete();
        pulse(1);
        for (int i = 0; i < 100 && cap1.size() < 13; i++) step();
        reset = 1'b0;
        #1;
        check("midrst_txdata",  txdata1,  8'h00);
        check("midrst_txclk",   txclk1,   1'b0);
        check("midrst_busy",    busy1,    1'b0);
        check("midrst_dropped", dropped1, 8'd0);
        steps(3);
        check("midrst_no_strobe", cap1.size(), 13);
        reset = 1'b1;
        step();
        alt = 16'h0042; vel = 16'h9876; fuel = 16'h0500; thrust = 16'h0011;
        model_frame(alt, vel, fuel, thrust, 1'b0, 1'b0);
        cap1.delete();
        pulse(1);
        wait_frame(1, 200, spent);
        check_frame("after_reset", 1);
        if (cap1.size() > 0) check("after_reset_first", cap1[0], 8'h41);

        // Negative and illegal digits with land set; the block then halts.
        alt = 16'h99F0; vel = 16'h8000; fuel = 16'h1234; thrust = 16'h0000; land = 1'b1; fail = 1'b0;
        model_frame(alt, vel, fuel, thrust, land, fail);
        cap1.delete();
        pulse(1);
        wait_frame(1, 200, spent);
        check_frame("neg_illegal", 1);
        steps(2);
        check("halt_busy", busy1, 1'b0);
        pulse(1);
        steps(3);
        check("halt_busy_after_update", busy1, 1'b0);
        check("halt_dropped", dropped1, 8'd1);
        check("halt_no_strobe", cap1.size(), 31);

        // Fail alone gives X and halts as well.
        reset = 1'b0; step(); reset = 1'b1; step();
        land = 1'b0; fail = 1'b1;
        model_frame(alt, vel, fuel, thrust, land, fail);
        cap1.delete();
        pulse(1);
        wait_frame(1, 200, spent);
        check_frame("fail_only", 1);
        if (cap1.size() > 28) check("fail_status", cap1[28], 8'h58);
        pulse(1);
        steps(2);
        check("fail_halt_dropped", dropped1, 8'd1);

        // Hand-written frames on the HOLDOFF=3 instance without halting.
        for (int i = 0; i < 4; i++) begin
            alt = tbl[i].a; vel = tbl[i].v; fuel = tbl[i].f; thrust = tbl[i].t;
            land = tbl[i].ld; fail = tbl[i].fl;
            exp_from_string(tbl[i].s);
            cap2.delete();
            pulse(2);
            wait_frame(2, 300, spent);
            check_frame($sformatf("table%0d", i), 2);
            check($sformatf("table%0d_cycles", i), spent, 125);
        end

        // Randomized frames with random backpressure and inputs scrambled mid-frame.
        for (int r = 0; r < 8; r++) begin
            ra = rand_bcd(); rv = rand_bcd(); rf = rand_bcd(); rt = rand_bcd();
            rl = ($urandom_range(0, 3) == 0); rx = ($urandom_range(0, 3) == 0);
            alt = ra; vel = rv; fuel = rf; thrust = rt; land = rl; fail = rx;
            model_frame(ra, rv, rf, rt, rl, rx);
            cap2.delete();
            pulse(2);
            for (int i = 0; i < 600; i++) begin
                if (cap2.size() >= 31 && !busy2) break;
                txready2 = ($urandom_range(0, 9) < 7);
                alt = 16'($urandom); land = 1'($urandom);
                step();
            end
            txready2 = 1'b1;
            check_frame($sformatf("rand%0d", r), 2);
        end

        check("dbl_strobe_dut", dbl1, 0);
        check("dbl_strobe_nh",  dbl2, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
